// File: rtl/tiny_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_cpu_pkg
//  Description : Shared types and constants for the TinyCpu program
//                sequencer: sequencer state encoding, instruction field
//                widths, default HALT opcode / NOP word and field helpers.
//  Ports       : none (package)
//  Options     : none
//  Revision    : 1.0  initial release
// ============================================================================
package tiny_cpu_pkg;

    localparam int OP_W    = 4;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = OP_W + DATA_W;

    localparam logic [OP_W-1:0]    HALT_OP_DEF  = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 12'h000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OP_W];
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [INSTR_W-1:0] word);
        return word[DATA_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tiny_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_prog_mem
//  Description : DEPTH x 12-bit program register file. Every word resets to
//                a HALT instruction. Synchronous write (enable is gated by
//                the caller), combinational read.
//  Ports       : clk, rst_n          clock / async active-low reset
//                we, wr_addr, wr_data write port
//                rd_addr, rd_data     combinational read port
//  Options     : none
//  Revision    : 1.0  initial release
// ============================================================================
module tiny_prog_mem
    import tiny_cpu_pkg::*;
#(
    parameter int               DEPTH   = 16,
    parameter int               AW      = $clog2(DEPTH),
    parameter logic [OP_W-1:0]  HALT_OP = HALT_OP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {HALT_OP, {DATA_W{1'b0}}};
            end
        end else if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so every rd_addr value is in range.
    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/tiny_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_cpu_sequencer
//  Description : Program sequencer for the TinyCpu datapath. Issues stored
//                12-bit words one at a time on CpuIn, inserts SETTLE_CYCLES
//                NOP cycles after each, captures CpuResult in the last
//                settle cycle, and stops on HALT, end of memory or Abort.
//  Ports       : Clk, Rst_n                  clock / async active-low reset
//                ProgWe, ProgAddr, ProgData  program write port (idle only)
//                Start, Abort                run control
//                CpuIn, CpuResult            TinyCpu In / Result
//                Busy, Done, Pc              status (Done is a 1-cycle pulse)
//                LastResult, ResultValid     captured result + update pulse
//                Step, StepMode              single-step control (optional)
//  Options     : TINY_SEQ_STEP_EN adds Step/StepMode single-step operation.
//  Revision    : 1.0  initial release
// ============================================================================
module tiny_cpu_sequencer
    import tiny_cpu_pkg::*;
#(
    parameter int                  DEPTH         = 16,
    parameter int                  AW            = $clog2(DEPTH),
    parameter int                  SETTLE_CYCLES = 1,
    parameter logic [INSTR_W-1:0]  NOP_WORD      = NOP_WORD_DEF,
    parameter logic [OP_W-1:0]     HALT_OP       = HALT_OP_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               ProgWe,
    input  logic [AW-1:0]      ProgAddr,
    input  logic [INSTR_W-1:0] ProgData,
    input  logic               Start,
    input  logic               Abort,
`ifdef TINY_SEQ_STEP_EN
    input  logic               Step,
    input  logic               StepMode,
`endif
    output logic [INSTR_W-1:0] CpuIn,
    input  logic [DATA_W-1:0]  CpuResult,
    output logic               Busy,
    output logic               Done,
    output logic [AW-1:0]      Pc,
    output logic [DATA_W-1:0]  LastResult,
    output logic               ResultValid
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    seq_state_t         r_state;
    logic               r_issued;      // CpuIn currently carries the word at Pc
    logic [CW-1:0]      r_settle_cnt;

    logic [AW-1:0]      w_rd_addr;
    logic [INSTR_W-1:0] w_word;
    logic               w_is_halt;
    logic               w_auto_issue;  // issue immediately on entering ISSUE
    logic               w_step_go;     // a waiting ISSUE may issue now
    logic               w_entry_go;
    logic               w_last_settle;
    logic               w_at_end;

    tiny_prog_mem #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .HALT_OP (HALT_OP)
    ) u_mem (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .we      (ProgWe & ~Busy),
        .wr_addr (ProgAddr),
        .wr_data (ProgData),
        .rd_addr (w_rd_addr),
        .rd_data (w_word)
    );

    // Outputs are registered, so the word is fetched for the address that
    // will be current in the next cycle: 0 on Start, Pc+1 when leaving SETTLE.
    always_comb begin
        w_rd_addr = Pc;
        case (r_state)
            IDLE:    w_rd_addr = '0;
            SETTLE:  w_rd_addr = Pc + AW'(1);
            default: w_rd_addr = Pc;
        endcase
    end

`ifdef TINY_SEQ_STEP_EN
    assign w_auto_issue = ~StepMode;
    assign w_step_go    = ~StepMode | Step;
`else
    assign w_auto_issue = 1'b1;
    assign w_step_go    = 1'b1;
`endif

    assign w_is_halt     = (op_of(w_word) == HALT_OP);
    assign w_entry_go    = w_auto_issue & ~w_is_halt;
    assign w_last_settle = (r_settle_cnt == CW'(1));
    assign w_at_end      = (Pc == AW'(DEPTH - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= IDLE;
            r_issued     <= 1'b0;
            r_settle_cnt <= '0;
            CpuIn        <= NOP_WORD;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Pc           <= '0;
            LastResult   <= '0;
            ResultValid  <= 1'b0;
        end else begin
            Done        <= 1'b0;
            ResultValid <= 1'b0;
            if (Abort) begin
                r_state      <= IDLE;
                r_issued     <= 1'b0;
                r_settle_cnt <= '0;
                CpuIn        <= NOP_WORD;
                Busy         <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (Start) begin
                            Pc       <= '0;
                            r_state  <= ISSUE;
                            Busy     <= 1'b1;
                            CpuIn    <= w_entry_go ? w_word : NOP_WORD;
                            r_issued <= w_entry_go;
                        end
                    end
                    ISSUE: begin
                        if (r_issued) begin
                            r_state      <= SETTLE;
                            CpuIn        <= NOP_WORD;
                            r_issued     <= 1'b0;
                            r_settle_cnt <= CW'(SETTLE_CYCLES);
                        end else if (w_is_halt) begin
                            // HALT is never driven onto CpuIn
                            r_state <= DONE;
                            Done    <= 1'b1;
                            Busy    <= 1'b0;
                            CpuIn   <= NOP_WORD;
                        end else if (w_step_go) begin
                            CpuIn    <= w_word;
                            r_issued <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        r_settle_cnt <= r_settle_cnt - CW'(1);
                        if (w_last_settle) begin
                            LastResult  <= CpuResult;
                            ResultValid <= 1'b1;
                            if (w_at_end) begin
                                // no wrap: the last word ends the program
                                r_state <= DONE;
                                Done    <= 1'b1;
                                Busy    <= 1'b0;
                            end else begin
                                Pc       <= Pc + AW'(1);
                                r_state  <= ISSUE;
                                CpuIn    <= w_entry_go ? w_word : NOP_WORD;
                                r_issued <= w_entry_go;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tiny_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiny_cpu_sequencer
//  Description : Self-checking bench for tiny_cpu_sequencer. A program-level
//                model expands each Start into the expected per-cycle trace
//                of CpuIn/Busy/Done/ResultValid/Pc; a compare process checks
//                every cycle against it, and directed literal checks pin the
//                model. Step tests are built when TINY_SEQ_STEP_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tiny_cpu_sequencer;

    localparam int          DEPTH  = 16;
    localparam int          AW     = 4;
    localparam int          SETTLE = 1;
    localparam logic [11:0] NOP    = 12'h000;
    localparam logic [3:0]  HALT   = 4'hF;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b1;
    logic          ProgWe = 1'b0;
    logic [AW-1:0] ProgAddr = '0;
    logic [11:0]   ProgData = '0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [7:0]    CpuResult = '0;
`ifdef TINY_SEQ_STEP_EN
    logic          Step = 1'b0;
    logic          StepMode = 1'b0;
`endif
    logic [11:0]   CpuIn;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] Pc;
    logic [7:0]    LastResult;
    logic          ResultValid;

    tiny_cpu_sequencer #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .ProgWe      (ProgWe),
        .ProgAddr    (ProgAddr),
        .ProgData    (ProgData),
        .Start       (Start),
        .Abort       (Abort),
`ifdef TINY_SEQ_STEP_EN
        .Step        (Step),
        .StepMode    (StepMode),
`endif
        .CpuIn       (CpuIn),
        .CpuResult   (CpuResult),
        .Busy        (Busy),
        .Done        (Done),
        .Pc          (Pc),
        .LastResult  (LastResult),
        .ResultValid (ResultValid)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b1;

    typedef struct {
        int            cyc;
        logic [11:0]   cin;
        bit            busy;
        bit            done;
        bit            rv;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t        q[$];
    logic [11:0] mdl_mem [DEPTH];
    logic [7:0]  hist [int];
    logic [7:0]  exp_last = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // TinyCpu stand-in: a fresh random Result every cycle, remembered per cycle
    always @(posedge Clk) begin
        #1;
        CpuResult = 8'($urandom);
        hist[cyc] = CpuResult;
    end

    function automatic void push(input int c, input logic [11:0] cin, input bit busy,
                                 input bit done, input bit rv, input int pc);
        exp_t e;
        e.cyc = c; e.cin = cin; e.busy = busy; e.done = done; e.rv = rv; e.pc = AW'(pc);
        q.push_back(e);
    endfunction

    // Program-level expansion: each word costs 1 issue + SETTLE nop cycles,
    // the result appears the cycle after the last settle, HALT costs one
    // NOP cycle, and Done follows HALT or the last address.
    function automatic void build_trace(input int c0);
        int c;
        bit pend;
        logic [11:0] w;
        c = c0;
        pend = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            w = mdl_mem[a];
            if (w[11:8] == HALT) begin
                push(c, NOP, 1'b1, 1'b0, pend, a);
                push(c + 1, NOP, 1'b0, 1'b1, 1'b0, a);
                return;
            end
            push(c, w, 1'b1, 1'b0, pend, a);
            c++;
            for (int s = 0; s < SETTLE; s++) begin
                push(c, NOP, 1'b1, 1'b0, 1'b0, a);
                c++;
            end
            pend = 1'b1;
        end
        push(c, NOP, 1'b0, 1'b1, pend, DEPTH - 1);
    endfunction

    function automatic bit busy_now();
        return q.size() > 0 && q[0].cyc == cyc && q[0].busy;
    endfunction

    always @(negedge Clk) begin : p_check
        exp_t e;
        if (Rst_n && chk_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                void'(q.pop_front());
                tests++;
                fails++;
                $display("FAIL trace_skew at cycle %0d: stale expectation dropped", cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
            end else begin
                e.cyc = cyc; e.cin = NOP; e.busy = 1'b0; e.done = 1'b0; e.rv = 1'b0; e.pc = '0;
            end
            if (e.rv) exp_last = hist[cyc - 1];
            chk("cpu_in", CpuIn, e.cin);
            chk("busy", Busy, e.busy);
            chk("done", Done, e.done);
            chk("result_valid", ResultValid, e.rv);
            chk("last_result", LastResult, exp_last);
            if (e.cyc == cyc && (e.busy || e.done)) chk("pc", Pc, e.pc);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [11:0] d);
        ProgWe = 1'b1;
        ProgAddr = AW'(a);
        ProgData = d;
        if (!busy_now()) mdl_mem[a] = d;
        tick();
        ProgWe = 1'b0;
    endtask

    task automatic start_run();
        Start = 1'b1;
        build_trace(cyc + 1);
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_run();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 500) begin
            tick();
            guard++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL run_timeout at cycle %0d: %0d expectations left", cyc, q.size());
            q.delete();
        end
        tick();
    endtask

    task automatic do_abort();
        Abort = 1'b1;
        while (q.size() > 0 && q[q.size() - 1].cyc > cyc) void'(q.pop_back());
        tick();
        Abort = 1'b0;
    endtask

    function automatic logic [11:0] rand_word();
        logic [11:0] w;
        w[11:8] = 4'($urandom_range(1, 14));
        w[7:0]  = 8'($urandom);
        return w;
    endfunction

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        int s;
        int n;
        int nw;
        int len;
        logic [11:0] w;
        logic [11:0] plan [8];

        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = {HALT, 8'h00};
        #2;
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_cpu_in", CpuIn, 12'h000);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_done", Done, 1'b0);
        chk("reset_pc", Pc, 4'd0);
        chk("reset_last_result", LastResult, 8'h00);
        chk("reset_result_valid", ResultValid, 1'b0);
        Rst_n = 1'b1;
        tick();

        // Basic program with literal per-cycle expectations
        write_word(0, 12'h105);
        write_word(1, 12'h203);
        write_word(2, 12'h300);
        write_word(3, 12'hF00);
        plan = '{12'h105, 12'h000, 12'h203, 12'h000, 12'h300, 12'h000, 12'h000, 12'h000};
        start_run();
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            chk("plan_cpu_in", CpuIn, plan[k - 1]);
            chk("plan_done", Done, k == 8);
            chk("plan_busy", Busy, k < 8);
            if (ResultValid) n++;
            tick();
        end
        chk("plan_result_pulses", n, 3);
        wait_run();

        // Start and Abort together in IDLE: Abort wins
        Start = 1'b1;
        Abort = 1'b1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        chk("start_abort_busy", Busy, 1'b0);
        repeat (3) tick();

        // Abort during SETTLE of word 2
        for (int a = 0; a < 5; a++) write_word(a, rand_word());
        write_word(5, 12'hF00);
        s = cyc;
        start_run();
        repeat (5) tick();
        chk("abort_pc_before", Pc, 4'd2);
        do_abort();
        chk("abort_cpu_in", CpuIn, 12'h000);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        chk("abort_last_result", LastResult, hist[s + 4]);
        repeat (3) tick();
        start_run();
        wait_run();

        // Program writes while Busy are dropped
        write_word(0, 12'h111);
        write_word(1, 12'h122);
        write_word(2, 12'h133);
        write_word(3, 12'h3C3);
        write_word(4, 12'hF00);
        start_run();
        tick();
        write_word(3, 12'h1AA);
        wait_run();
        start_run();
        wait_run();

        // Full memory of non-HALT words: 16 issues, no wrap
        for (int a = 0; a < DEPTH; a++) write_word(a, rand_word());
        start_run();
        n = 0;
        while (q.size() > 0 && n < 100) begin
            if (CpuIn != NOP) n++;
            tick();
        end
        chk("full_issue_count", n, 16);
        chk("full_final_pc", Pc, 4'd15);
        wait_run();

        // Randomised programs with occasional aborts
        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(2, 8);
            for (int k = 0; k < nw; k++) begin
                w = rand_word();
                if ($urandom_range(0, 4) == 0) w[11:8] = HALT;
                write_word($urandom_range(0, DEPTH - 1), w);
            end
            start_run();
            if ($urandom_range(0, 2) == 0) begin
                len = q.size();
                repeat ($urandom_range(0, len)) tick();
                do_abort();
            end
            wait_run();
        end

        // Asynchronous reset in the middle of ISSUE
        write_word(0, 12'h155);
        start_run();
        Rst_n = 1'b0;
        #1;
        chk("midrst_cpu_in", CpuIn, 12'h000);
        chk("midrst_busy", Busy, 1'b0);
        chk("midrst_done", Done, 1'b0);
        chk("midrst_pc", Pc, 4'd0);
        chk("midrst_last_result", LastResult, 8'h00);
        chk("midrst_result_valid", ResultValid, 1'b0);
        q.delete();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = {HALT, 8'h00};
        exp_last = 8'h00;
        tick();
        Rst_n = 1'b1;
        tick();
        start_run();
        chk("midrst_halt_busy", Busy, 1'b1);
        chk("midrst_halt_cpu_in", CpuIn, 12'h000);
        tick();
        chk("midrst_halt_done", Done, 1'b1);
        wait_run();

`ifdef TINY_SEQ_STEP_EN
        // Single-step: one issue and one result per Step pulse
        chk_en = 1'b0;
        write_word(0, 12'h111);
        write_word(1, 12'h122);
        write_word(2, 12'hF00);
        StepMode = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("step_wait_cpu_in", CpuIn, 12'h000);
            chk("step_wait_busy", Busy, 1'b1);
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            Step = 1'b1;
            tick();
            Step = 1'b0;
            chk("step_issue", CpuIn, (j == 0) ? 12'h111 : 12'h122);
            n = 0;
            repeat (4) begin
                tick();
                if (ResultValid) n++;
            end
            chk("step_result_pulses", n, 1);
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        StepMode = 1'b0;
        chk("step_abort_busy", Busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
